rr_arb8: RTL

Eight-requester round-robin arbiter that shares one downstream resource, such as a priority-encoded datapath lane, between up to eight clients. It registers a one-hot grant and a 3-bit encoded grant index (same encoding as the 8:3 encoder: index n for bit n). It holds the grant until the owner drops its request, then rotates priority past the last owner. It sits between the requesting agents and the shared resource's enable and select inputs.

---
 rtl/rr_arb8_pkg.sv | 20 ++
 rtl/prio_enc8_rr.sv | 30 +++
 rtl/rr_arb8.sv | 108 ++++++++++
 3 files changed

// File: rtl/rr_arb8_pkg.sv
// Shared types and constants for the eight-requester round-robin arbiter.
// Includes a helper that turns a grant index into a one-hot grant vector.
package rr_arb8_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] oh;
        oh = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/prio_enc8_rr.sv
// Rotating find-first: returns the first set request scanning ptr, ptr+1, ... wrapping mod 8.
// Purely combinational; found_o is low when no request is set.
module prio_enc8_rr
    import rr_arb8_pkg::*;
(
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [N_REQ-1:0] rot;
    logic [IDX_W-1:0] pos;

    // Rotate right by ptr so the highest-priority client lands at bit 0.
    assign rot = (req_i >> ptr_i) | (req_i << (IDX_W'(0) - ptr_i));

    always_comb begin
        pos = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                pos = IDX_W'(i);
            end
        end
    end

    assign found_o = |req_i;
    assign idx_o   = pos + ptr_i;

endmodule

// File: rtl/rr_arb8.sv
// Eight-way round-robin arbiter with registered one-hot grant, held until the owner drops req.
// Optional grant timeout compiled in with RR_ARB8_TIMEOUT_EN (limit set by MAX_HOLD).
module rr_arb8
    import rr_arb8_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld,
    output logic             tmo
);

    if (MAX_HOLD < 2 || MAX_HOLD > 256) begin : g_bad_max_hold
        $error("rr_arb8: MAX_HOLD must lie in 2..256");
    end

    state_t           state_q;
    logic [IDX_W-1:0] ptr_q;
    logic [N_REQ-1:0] gnt_q;
    logic [IDX_W-1:0] idx_q;
    logic             vld_q;
    logic             tmo_q;

    logic             win_found;
    logic [IDX_W-1:0] win_idx;

`ifdef RR_ARB8_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD);
    logic [HOLD_W-1:0] hold_q;
`endif

    prio_enc8_rr u_prio_enc (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .found_o (win_found),
        .idx_o   (win_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            idx_q   <= '0;
            vld_q   <= 1'b0;
            tmo_q   <= 1'b0;
`ifdef RR_ARB8_TIMEOUT_EN
            hold_q  <= '0;
`endif
        end else begin
            tmo_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (en && win_found) begin
                        gnt_q   <= idx_to_onehot(win_idx);
                        idx_q   <= win_idx;
                        vld_q   <= 1'b1;
                        state_q <= GRANT;
`ifdef RR_ARB8_TIMEOUT_EN
                        hold_q  <= '0;
`endif
                    end
                end
                GRANT: begin
                    // Disable wins over release, so priority stays where it was.
                    if (!en) begin
                        gnt_q   <= '0;
                        idx_q   <= '0;
                        vld_q   <= 1'b0;
                        state_q <= IDLE;
                    end else if (!req[idx_q]) begin
                        gnt_q   <= '0;
                        idx_q   <= '0;
                        vld_q   <= 1'b0;
                        ptr_q   <= idx_q + IDX_W'(1);
                        state_q <= IDLE;
                    end
`ifdef RR_ARB8_TIMEOUT_EN
                    else if (hold_q == HOLD_W'(MAX_HOLD - 1)) begin
                        gnt_q   <= '0;
                        idx_q   <= '0;
                        vld_q   <= 1'b0;
                        ptr_q   <= idx_q + IDX_W'(1);
                        tmo_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        hold_q  <= hold_q + HOLD_W'(1);
                    end
`endif
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign gnt     = gnt_q;
    assign gnt_idx = idx_q;
    assign gnt_vld = vld_q;
    assign tmo     = tmo_q;

endmodule
